instr_encoder: RTL
==================

# instr_encoder

Sequential program-loader / instruction encoder for the single-cycle MIPS core: the inverse of opcode decoding. It accepts symbolic operation descriptors over a valid/ready handshake and packs each one into a 32-bit MIPS instruction word. It writes the words to consecutive instruction-memory locations and reports count, XOR checksum and errors. It sits between the test/boot host and the instruction memory write port.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after start
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse: (re)initialise load session
- op_valid_i  in  1  descriptor valid
- op_ready_o  out  1  descriptor accepted when valid&ready
- op_kind_i  in  4  operation kind (see Operation)
- op_last_i  in  1  descriptor is last of program
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register/shift fields
- funct_i  in  6  R-type function field
- imm_i  in  16  I-type immediate
- target_i  in  26  J-type word target
- mem_we_o  out  1  write strobe, held until mem_ready_i
- mem_addr_o  out  ADDR_WIDTH  write word address
- mem_data_o  out  32  encoded instruction
- mem_ready_i  in  1  memory accepts write this cycle
- count_o  out  ADDR_WIDTH+1  words written this session
- checksum_o  out  32  XOR of all words written
- done_o  out  1  session finished (level)
- full_o  out  1  last address written (sticky)
- err_o  out  1  illegal kind seen (sticky)

## Operation
- Kinds: 0 R, 1 ADDI, 2 ORI, 3 LUI, 4 ANDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 JAL; 11–15 illegal.
- Opcodes: R 0x00, ADDI 0x08, ORI 0x0d, LUI 0x0f, ANDI 0x0c, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- R: {6'h00, rs, rt, rd, shamt, funct}. I: {opc, rs, rt, imm}; LUI forces rs=0. J/JAL: {opc, target}.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: op_ready_o=0; start_i -> ACCEPT.
  - ACCEPT: op_ready_o=1; handshake with legal kind -> register word, -> WRITE. Illegal kind: descriptor consumed, nothing written, err_o set, stay ACCEPT; if op_last_i also set -> DONE.
  - WRITE: mem_we_o=1, addr/data stable. On mem_ready_i: count++, checksum ^= word, addr++. Then -> DONE if op_last_i was set or addr was 2^ADDR_WIDTH-1 (full_o set); else -> ACCEPT.
  - DONE: done_o=1, op_ready_o=0; start_i -> ACCEPT.
- start_i has priority in every state. It sets addr=BASE_ADDR and clears count, checksum, done_o, full_o and err_o. It drops any pending write and -> ACCEPT.
- Address never wraps; descriptors offered in DONE stall (ready=0).

## Timing
- Reset (async, reset=0): state IDLE; all outputs 0 except mem_addr_o=BASE_ADDR.
- Accept at edge N -> mem_we_o and mem_data_o valid from cycle N+1. Write completes at the first edge with mem_ready_i=1. op_ready_o is high the cycle after completion. Peak throughput is 1 word per 2 cycles.
- count_o and checksum_o update on the write-completing edge.
- done_o and full_o rise the cycle after the final completing write.
- Reset asserted mid-WRITE aborts the write immediately: mem_we_o drops asynchronously.

## Structure
- Shared package mips_pkg holds the opcode constants (same values as the control decoder) and the 4-bit kind encoding. Both blocks import it.
- One combinational sub-module, instr_word_pack, maps kind plus fields to {legal, word[31:0]}. The FSM, counters and checksum stay in instr_encoder.

## Test plan
- Reset, start, kind 1 rs=0 rt=8 imm=5 with last -> single write 0x20080005 @BASE_ADDR; count 1, checksum 0x20080005, done_o=1.
- Sequence: R rs=8 rt=9 rd=10 funct=0x20; LW rs=8 rt=9 imm=4; J target=0x100000 (last) -> 0x01095020, 0x8D090004, 0x08100000 at addr 0,1,2; checksum = XOR of the three words.
- mem_ready_i held low 3 cycles -> mem_we_o/addr/data stable 4 cycles, op_ready_o low, single count increment.
- Kind 12 then ADDI -> err_o=1, only the ADDI is written at addr 0.
- ADDR_WIDTH=2, five ops without last -> four writes (addr 0–3), full_o=1, done_o=1, fifth descriptor stalls.
- start_i during WRITE and async reset during WRITE -> mem_we_o drops, counters cleared, next write lands at BASE_ADDR.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes match the control decoder, plus the
// 4-bit operation-kind code used by the program loader.
package mips_pkg;

    typedef enum logic [3:0] {
        K_R    = 4'd0,
        K_ADDI = 4'd1,
        K_ORI  = 4'd2,
        K_LUI  = 4'd3,
        K_ANDI = 4'd4,
        K_LW   = 4'd5,
        K_SW   = 4'd6,
        K_BEQ  = 4'd7,
        K_BNE  = 4'd8,
        K_J    = 4'd9,
        K_JAL  = 4'd10
    } kind_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: operation kind plus operand fields -> 32-bit MIPS word.
// Kinds outside the table come back with legal_o=0 and a zero word.
module instr_word_pack
    import mips_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic        legal_o,
    output logic [31:0] word_o
);

    always_comb begin
        legal_o = 1'b1;
        word_o  = '0;
        case (kind_i)
            K_R:    word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            K_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
            K_ORI:  word_o = {OPC_ORI, rs_i, rt_i, imm_i};
            // LUI has no source register; the rs slot must read as zero
            K_LUI:  word_o = {OPC_LUI, 5'd0, rt_i, imm_i};
            K_ANDI: word_o = {OPC_ANDI, rs_i, rt_i, imm_i};
            K_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
            K_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
            K_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, imm_i};
            K_BNE:  word_o = {OPC_BNE, rs_i, rt_i, imm_i};
            K_J:    word_o = {OPC_J, target_i};
            K_JAL:  word_o = {OPC_JAL, target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts operation descriptors, packs them into MIPS words and
// writes them to consecutive instruction-memory addresses with count/checksum.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [3:0]            op_kind_i,
    input  logic                  op_last_i,
    input  logic [4:0]            rs_i,
    input  logic [4:0]            rt_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            shamt_i,
    input  logic [5:0]            funct_i,
    input  logic [15:0]           imm_i,
    input  logic [25:0]           target_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [31:0]           checksum_o,
    output logic                  done_o,
    output logic                  full_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           cksum_q, cksum_d;
    logic [31:0]           word_q, word_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;

    logic                  pack_legal;
    logic [31:0]           pack_word;

    instr_word_pack u_pack (
        .kind_i   (op_kind_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .rd_i     (rd_i),
        .shamt_i  (shamt_i),
        .funct_i  (funct_i),
        .imm_i    (imm_i),
        .target_i (target_i),
        .legal_o  (pack_legal),
        .word_o   (pack_word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        cksum_d = cksum_q;
        word_d  = word_q;
        last_d  = last_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        if (start_i) begin
            // a new session wins over everything, including a pending write
            state_d = S_ACCEPT;
            addr_d  = BASE_ADDR;
            count_d = '0;
            cksum_d = '0;
            done_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (op_valid_i) begin
                        if (pack_legal) begin
                            word_d  = pack_word;
                            last_d  = op_last_i;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                            if (op_last_i) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready_i) begin
                        count_d = count_q + (ADDR_WIDTH+1)'(1);
                        cksum_d = cksum_q ^ word_q;
                        if (last_q || addr_q == ADDR_MAX) begin
                            // address is held at the top rather than wrapping
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            full_d  = full_q | (addr_q == ADDR_MAX);
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = S_ACCEPT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            cksum_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            cksum_q <= cksum_d;
            word_q  <= word_d;
            last_q  <= last_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign op_ready_o = (state_q == S_ACCEPT);
    assign mem_we_o   = (state_q == S_WRITE);
    assign mem_addr_o = addr_q;
    assign mem_data_o = word_q;
    assign count_o    = count_q;
    assign checksum_o = cksum_q;
    assign done_o     = done_q;
    assign full_o     = full_q;
    assign err_o      = err_q;

endmodule
